// File: rtl/mdu_if.sv
// Handshake and result bundle between the EX stage and the multiply/divide unit.
interface mdu_if;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rd_data;

  // EX stage side: issues operations, observes status and HI/LO
  modport master (
    output op_valid, op, a, b,
    input  busy, stall, hi, lo, rd_data
  );

  // MDU side: consumes operations, owns HI/LO
  modport slave (
    input  op_valid, op, a, b,
    output busy, stall, hi, lo, rd_data
  );
endinterface

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide controller for the EX stage.
// Owns HI/LO and models a fixed latency per operation with a busy counter.
// While busy, any MDU instruction presented by EX is stalled.
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic reset,
  mdu_if.slave bus
);

  localparam int CMAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV
  } state_t;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_MFHI  = 3'd6,
    OP_MFLO  = 3'd7
  } op_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;
  logic        sgn_q, sgn_d;

  op_t         op_in;
  logic        busy;

  logic [63:0] prod;
  logic [31:0] ua, ub, uq, ur;
  logic [31:0] quot, rem;
  logic        neg_q, neg_r;

  assign op_in = op_t'(bus.op);
  assign busy  = (state_q != S_IDLE);

  // Product of the captured operands, signed or unsigned per the accepted op
  always_comb begin
    prod = '0;
    if (sgn_q) begin
      prod = {{32{opa_q[31]}}, opa_q} * {{32{opb_q[31]}}, opb_q};
    end else begin
      prod = {32'd0, opa_q} * {32'd0, opb_q};
    end
  end

  // Signed division via magnitudes: quotient truncates toward zero and the
  // remainder takes the dividend's sign. 0x80000000 / -1 falls out naturally
  // as 0x80000000 remainder 0 because the magnitude fits in 32 unsigned bits.
  always_comb begin
    neg_q = sgn_q & (opa_q[31] ^ opb_q[31]);
    neg_r = sgn_q & opa_q[31];
    ua    = (sgn_q && opa_q[31]) ? (32'd0 - opa_q) : opa_q;
    ub    = (sgn_q && opb_q[31]) ? (32'd0 - opb_q) : opb_q;
    uq    = '0;
    ur    = '0;
    if (ub != '0) begin
      uq = ua / ub;
      ur = ua % ub;
    end
    quot = neg_q ? (32'd0 - uq) : uq;
    rem  = neg_r ? (32'd0 - ur) : ur;
  end

  // Next-state: accept in IDLE, count down while busy, commit HI/LO at zero
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sgn_d   = sgn_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.op_valid) begin
          unique case (op_in)
            OP_MULT, OP_MULTU: begin
              state_d = S_MUL;
              cnt_d   = CW'(MULT_CYCLES - 1);
              opa_d   = bus.a;
              opb_d   = bus.b;
              sgn_d   = (op_in == OP_MULT);
            end
            OP_DIV, OP_DIVU: begin
              state_d = S_DIV;
              cnt_d   = CW'(DIV_CYCLES - 1);
              opa_d   = bus.a;
              opb_d   = bus.b;
              sgn_d   = (op_in == OP_DIV);
            end
            OP_MTHI: hi_d = bus.a;
            OP_MTLO: lo_d = bus.a;
            default: ;
          endcase
        end
      end
      S_MUL: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          hi_d    = prod[63:32];
          lo_d    = prod[31:0];
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DIV: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          if (opb_q != '0) begin
            hi_d = rem;
            lo_d = quot;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counter, HI/LO and captured operands; reset discards any in-flight op
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      sgn_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sgn_q   <= sgn_d;
    end
  end

  // Read port for MFHI/MFLO, zero for every other op or when nothing is presented
  always_comb begin
    bus.rd_data = '0;
    if (bus.op_valid) begin
      if (op_in == OP_MFHI) begin
        bus.rd_data = hi_q;
      end else if (op_in == OP_MFLO) begin
        bus.rd_data = lo_q;
      end
    end
  end

  // Status outputs; stall depends only on busy, never on this cycle's accept
  always_comb begin
    bus.busy  = busy;
    bus.stall = bus.op_valid & busy;
    bus.hi    = hi_q;
    bus.lo    = lo_q;
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Randomized scoreboard bench for mdu_ctrl against an arithmetic reference model.
module tb_mdu_ctrl;

  localparam int MC = 5;
  localparam int DC = 10;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mdu_if bus ();

  mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
    logic [2:0]  op;
  } exp_t;

  exp_t sb[$];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Model state: architectural HI/LO plus the last cycle index that is busy
  logic [31:0] hi_m = '0;
  logic [31:0] lo_m = '0;
  logic [31:0] pend_hi, pend_lo;
  bit          pend = 0;
  int          busy_last = -1;
  bit          abort = 1;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Reference arithmetic straight from the instruction definitions
  function automatic void compute(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                  output bit w, output logic [31:0] h, output logic [31:0] l);
    int sx, sy;
    longint sp;
    logic [63:0] up;
    sx = x;
    sy = y;
    w = 1;
    h = '0;
    l = '0;
    case (o)
      3'd0: begin
        sp = longint'(sx) * longint'(sy);
        h = sp[63:32];
        l = sp[31:0];
      end
      3'd1: begin
        up = {32'd0, x} * {32'd0, y};
        h = up[63:32];
        l = up[31:0];
      end
      3'd2: begin
        if (y == 32'd0) w = 0;
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
          l = 32'h8000_0000;
          h = 32'd0;
        end else begin
          l = sx / sy;
          h = sx % sy;
        end
      end
      3'd3: begin
        if (y == 32'd0) w = 0;
        else begin
          l = x / y;
          h = x % y;
        end
      end
      default: w = 0;
    endcase
  endfunction

  function automatic logic [31:0] rnd_val();
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0: v = 32'd0;
      1: v = 32'hFFFF_FFFF;
      2: v = 32'h8000_0000;
      3: v = $urandom_range(0, 20);
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // One EX cycle: drive inputs, check combinational outputs and HI/LO, update the model
  task automatic cycle(input bit v, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    int k;
    bit eb;
    bit w;
    logic [31:0] h, l;
    exp_t e;
    @(negedge clk);
    k = cyc;
    if (pend && k == busy_last + 1) begin
      hi_m = pend_hi;
      lo_m = pend_lo;
      pend = 0;
    end
    bus.op_valid = v;
    bus.op = o;
    bus.a = x;
    bus.b = y;
    #1;
    eb = (k <= busy_last);
    chk("stall", 32'(bus.stall), 32'(v & eb));
    chk("hi", bus.hi, hi_m);
    chk("lo", bus.lo, lo_m);
    if (v && o == 3'd6) chk("mfhi", bus.rd_data, hi_m);
    if (v && o == 3'd7) chk("mflo", bus.rd_data, lo_m);
    if (v && !eb) begin
      case (o)
        3'd0, 3'd1, 3'd2, 3'd3: begin
          compute(o, x, y, w, h, l);
          e.lat = (o < 3'd2) ? MC : DC;
          busy_last = k + e.lat;
          pend = 1;
          pend_hi = w ? h : hi_m;
          pend_lo = w ? l : lo_m;
          e.hi = pend_hi;
          e.lo = pend_lo;
          e.op = o;
          sb.push_back(e);
        end
        3'd4: hi_m = x;
        3'd5: lo_m = x;
        default: ;
      endcase
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    abort = 1;
    reset = 1'b0;
    bus.op_valid = 1'b0;
    repeat (n) @(negedge clk);
    reset = 1'b1;
    hi_m = '0;
    lo_m = '0;
    pend = 0;
    busy_last = -1;
    sb.delete();
    #1;
    chk("rst_hi", bus.hi, 32'd0);
    chk("rst_lo", bus.lo, 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_stall", 32'(bus.stall), 32'd0);
    abort = 0;
  endtask

  // Monitor: measures each busy run and checks the committed result when busy drops
  initial begin
    int run;
    bit prev;
    exp_t e;
    run = 0;
    prev = 0;
    forever begin
      @(negedge clk);
      #2;
      if (abort) begin
        run = 0;
        prev = 0;
      end else begin
        if (bus.busy) begin
          run++;
          if (run > 64) begin
            chk("busy_timeout", 32'(run), 32'(DC));
            run = 0;
          end
        end else if (prev) begin
          if (sb.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            chk("res_hi", bus.hi, e.hi);
            chk("res_lo", bus.lo, e.lo);
            chk("latency", 32'(run), 32'(e.lat));
          end
          run = 0;
        end
        prev = bus.busy;
      end
    end
  end

  initial begin
    bit v;
    logic [2:0] o;
    bus.op_valid = 1'b0;
    bus.op = '0;
    bus.a = '0;
    bus.b = '0;

    do_reset(1);

    cycle(1, 3'd0, 32'hFFFF_FFFE, 32'd3);
    repeat (7) cycle(0, 3'd0, '0, '0);

    cycle(1, 3'd1, 32'hFFFF_FFFF, 32'd2);
    repeat (7) cycle(0, 3'd1, $urandom, $urandom);

    cycle(1, 3'd2, 32'hFFFF_FFF9, 32'd2);
    repeat (11) cycle(0, 3'd0, '0, '0);
    cycle(1, 3'd3, 32'd7, 32'd0);
    repeat (11) cycle(0, 3'd0, '0, '0);

    cycle(1, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    repeat (11) cycle(0, 3'd0, '0, '0);

    cycle(1, 3'd2, 32'd100, 32'd7);
    repeat (12) cycle(1, 3'd7, '0, '0);

    cycle(1, 3'd4, 32'h0000_1234, 32'd0);
    cycle(0, 3'd0, '0, '0);
    cycle(1, 3'd0, 32'h0001_0000, 32'h0001_0003);
    repeat (2) cycle(0, 3'd0, '0, '0);
    do_reset(1);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 120) == 0) begin
        do_reset($urandom_range(1, 2));
      end else begin
        v = ($urandom_range(0, 3) != 0);
        o = 3'($urandom_range(0, 7));
        cycle(v, o, rnd_val(), rnd_val());
      end
    end

    repeat (DC + 3) cycle(0, 3'd0, '0, '0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
